// File: rtl/bo_datapath.sv
// Operative datapath for the polynomial controller: X/H/S working registers, operand muxes,
// a combinational adder and an iterative shift-add multiplier that stalls the controller via busy.
module bo_datapath #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] c_in,
    input  logic [1:0]       m0,
    input  logic [1:0]       m1,
    input  logic [1:0]       m2,
    input  logic             lx,
    input  logic             ls,
    input  logic             lh,
    input  logic             h,
    input  logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             ovf
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [1:0] WB_XIN  = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_S    = 2'b10;
    localparam logic [1:0] WB_ZERO = 2'b11;

    logic [0:0]       state_q,  state_d;
    logic [WIDTH-1:0] x_q,      x_d;
    logic [WIDTH-1:0] hr_q,     hr_d;
    logic [WIDTH-1:0] s_q,      s_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             rvalid_q, rvalid_d;
    logic             ovf_q,    ovf_d;
    logic [PW-1:0]    mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    prod_q,   prod_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [2:0]       en_q,     en_d;
    logic [1:0]       m2l_q,    m2l_d;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;
    logic             any_load;

    // Write-back source mux shared by the add path and the multiply completion
    function automatic logic [WIDTH-1:0] wb_value(input logic [1:0]       sel,
                                                  input logic [WIDTH-1:0] alu_v,
                                                  input logic [WIDTH-1:0] xin_v,
                                                  input logic [WIDTH-1:0] s_v);
        logic [WIDTH-1:0] v;
        case (sel)
            WB_XIN:  v = xin_v;
            WB_ALU:  v = alu_v;
            WB_S:    v = s_v;
            default: v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        case (m0)
            2'b00:   op_a = x_q;
            2'b01:   op_a = hr_q;
            2'b10:   op_a = s_q;
            default: op_a = a_in;
        endcase
    end

    always_comb begin
        case (m1)
            2'b00:   op_b = x_q;
            2'b01:   op_b = hr_q;
            2'b10:   op_b = b_in;
            default: op_b = c_in;
        endcase
    end

    assign sum      = {1'b0, op_a} + {1'b0, op_b};
    assign any_load = lx | ls | lh;

    // Next-state and datapath updates
    always_comb begin
        logic [WIDTH-1:0] wv;
        logic [PW-1:0]    prod_step;
        logic             ovf_set;
        logic             ovf_clr;

        state_d   = state_q;
        x_d       = x_q;
        hr_d      = hr_q;
        s_d       = s_q;
        result_d  = result_q;
        rvalid_d  = 1'b0;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        en_d      = en_q;
        m2l_d     = m2l_q;
        wv        = '0;
        prod_step = prod_q;
        ovf_set   = 1'b0;
        ovf_clr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (h) begin
                    if (any_load) begin
                        mcand_d  = PW'(op_a);
                        mplier_d = op_b;
                        en_d     = {lx, ls, lh};
                        m2l_d    = m2;
                        prod_d   = '0;
                        cnt_d    = '0;
                        state_d  = ST_MUL;
                    end
                end else begin
                    wv = wb_value(m2, sum[WIDTH-1:0], x_in, s_q);
                    if (lx) x_d  = wv;
                    if (ls) s_d  = wv;
                    if (lh) hr_d = wv;
                    ovf_set = sum[WIDTH] && (m2 == WB_ALU) && any_load;
                    ovf_clr = lx && (m2 == WB_XIN);
                end
                // done samples S before this edge's write-back
                if (done) begin
                    result_d = s_q;
                    rvalid_d = 1'b1;
                end
            end
            default: begin
                prod_step = mplier_q[0] ? (prod_q + (mcand_q << cnt_q)) : prod_q;
                prod_d    = prod_step;
                mplier_d  = mplier_q >> 1;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_d == CW'(WIDTH)) begin
                    state_d = ST_IDLE;
                    wv      = wb_value(m2l_q, prod_step[WIDTH-1:0], x_in, s_q);
                    if (en_q[2]) x_d  = wv;
                    if (en_q[1]) s_d  = wv;
                    if (en_q[0]) hr_d = wv;
                    ovf_set = (prod_step[PW-1:WIDTH] != '0);
                end
            end
        endcase

        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            hr_q     <= '0;
            s_q      <= '0;
            result_q <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            en_q     <= '0;
            m2l_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            hr_q     <= hr_d;
            s_q      <= s_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            m2l_q    <= m2l_d;
        end
    end

    assign result       = result_q;
    assign result_valid = rvalid_q;
    assign busy         = (state_q == ST_MUL);
    assign ovf          = ovf_q;

endmodule
